// File: rtl/pipelined_control_unit.sv
// ============================================================================
// Module   : pipelined_control_unit
// Purpose  : RV32 five-stage control decoder with D->E->M->W control pipeline.
//            Optional bne support is enabled by defining CTRL_BNE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipelined_control_unit (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zeroE,
    input  logic       FlushE,
    output logic [1:0] ImmSrcD,
    output logic       PCSrcE,
    output logic       ALUSrcE,
    output logic [2:0] ALUControlE,
    output logic       ResultSrcE0,
    output logic       MemWriteM,
    output logic       RegWriteM,
    output logic       RegWriteW,
    output logic [1:0] ResultSrcW
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    logic       w_reg_write;
    logic [1:0] w_imm_src;
    logic       w_alu_src;
    logic       w_mem_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_op;
    logic       w_branch;
    logic       w_jump;
    logic [2:0] w_alu_control;
    logic       w_taken;
    logic       w_unused;

    logic       r_reg_write_e;
    logic [1:0] r_result_src_e;
    logic       r_mem_write_e;
    logic       r_jump_e;
    logic       r_branch_e;
    logic [2:0] r_alu_control_e;
    logic       r_alu_src_e;

    logic       r_reg_write_m;
    logic [1:0] r_result_src_m;
    logic       r_mem_write_m;

    logic       r_reg_write_w;
    logic [1:0] r_result_src_w;

`ifdef CTRL_BNE_EN
    logic       w_branch_ne;
    logic       r_branch_ne_e;
`endif

    // Only funct7[5] participates in decode; the remaining bits are don't-care.
    assign w_unused = ^{func7[6], func7[4:0]};

    always_comb begin
        w_reg_write  = 1'b0;
        w_imm_src    = 2'b00;
        w_alu_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_result_src = 2'b00;
        w_alu_op     = 2'b00;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
`ifdef CTRL_BNE_EN
        w_branch_ne  = 1'b0;
`endif
        case (opcode)
            c_OP_LOAD: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_result_src = 2'b01;
            end
            c_OP_STORE: begin
                w_imm_src   = 2'b01;
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            c_OP_RTYPE: begin
                w_reg_write = 1'b1;
                w_alu_op    = 2'b10;
            end
            c_OP_ITYPE: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_alu_op    = 2'b10;
            end
            c_OP_BRANCH: begin
                // Unsupported branch conditions collapse to a full bubble.
                if (func3 == 3'b000) begin
                    w_branch  = 1'b1;
                    w_imm_src = 2'b10;
                    w_alu_op  = 2'b01;
                end
`ifdef CTRL_BNE_EN
                else if (func3 == 3'b001) begin
                    w_branch    = 1'b1;
                    w_branch_ne = 1'b1;
                    w_imm_src   = 2'b10;
                    w_alu_op    = 2'b01;
                end
`endif
            end
            c_OP_JAL: begin
                w_reg_write  = 1'b1;
                w_imm_src    = 2'b11;
                w_jump       = 1'b1;
                w_result_src = 2'b10;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_alu_control = c_ALU_ADD;
        case (w_alu_op)
            2'b01:   w_alu_control = c_ALU_SUB;
            2'b10: begin
                case (func3)
                    3'b000:  w_alu_control = (opcode[5] & func7[5]) ? c_ALU_SUB : c_ALU_ADD;
                    3'b010:  w_alu_control = c_ALU_SLT;
                    3'b110:  w_alu_control = c_ALU_OR;
                    3'b111:  w_alu_control = c_ALU_AND;
                    default: w_alu_control = c_ALU_ADD;
                endcase
            end
            default: w_alu_control = c_ALU_ADD;
        endcase
    end

    // Flush inserts a bubble into E only; M and W keep advancing.
    always_ff @(posedge clock) begin
        if (reset || FlushE) begin
            r_reg_write_e   <= 1'b0;
            r_result_src_e  <= 2'b00;
            r_mem_write_e   <= 1'b0;
            r_jump_e        <= 1'b0;
            r_branch_e      <= 1'b0;
            r_alu_control_e <= 3'b000;
            r_alu_src_e     <= 1'b0;
        end else begin
            r_reg_write_e   <= w_reg_write;
            r_result_src_e  <= w_result_src;
            r_mem_write_e   <= w_mem_write;
            r_jump_e        <= w_jump;
            r_branch_e      <= w_branch;
            r_alu_control_e <= w_alu_control;
            r_alu_src_e     <= w_alu_src;
        end
    end

`ifdef CTRL_BNE_EN
    always_ff @(posedge clock) begin
        if (reset || FlushE) begin
            r_branch_ne_e <= 1'b0;
        end else begin
            r_branch_ne_e <= w_branch_ne;
        end
    end
    assign w_taken = zeroE ^ r_branch_ne_e;
`else
    assign w_taken = zeroE;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_reg_write_m  <= 1'b0;
            r_result_src_m <= 2'b00;
            r_mem_write_m  <= 1'b0;
            r_reg_write_w  <= 1'b0;
            r_result_src_w <= 2'b00;
        end else begin
            r_reg_write_m  <= r_reg_write_e;
            r_result_src_m <= r_result_src_e;
            r_mem_write_m  <= r_mem_write_e;
            r_reg_write_w  <= r_reg_write_m;
            r_result_src_w <= r_result_src_m;
        end
    end

    assign ImmSrcD     = w_imm_src;
    assign PCSrcE      = (r_branch_e & w_taken) | r_jump_e;
    assign ALUSrcE     = r_alu_src_e;
    assign ALUControlE = r_alu_control_e;
    assign ResultSrcE0 = r_result_src_e[0];
    assign MemWriteM   = r_mem_write_m;
    assign RegWriteM   = r_reg_write_m;
    assign RegWriteW   = r_reg_write_w;
    assign ResultSrcW  = r_result_src_w;

endmodule

`default_nettype wire

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Pipelined control unit for the five-stage RISC-V core. It decodes `opcode`/`func3`/`func7` from the decode stage and drives the datapath's per-stage control inputs. Control bits travel through its own D→E→M→W pipeline registers, in lock-step with the datapath stage registers. It also exports the per-stage control state the hazard unit needs for load-use stalls and forwarding.

## Interface
Parameters: none.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all pipeline control registers
- `opcode`  in  7  decode-stage instruction opcode
- `func3`  in  3  decode-stage funct3
- `func7`  in  7  decode-stage funct7
- `zeroE`  in  1  ALU zero flag from execute
- `FlushE`  in  1  from hazard unit; loads a bubble into the E control register
- `ImmSrcD`  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
- `PCSrcE`  out  1  branch/jump taken in execute; selects `pc_target`
- `ALUSrcE`  out  1  0 = register operand B, 1 = immediate
- `ALUControlE`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `ResultSrcE0`  out  1  bit 0 of `ResultSrcE`; 1 = load in execute (load-use detection)
- `MemWriteM`  out  1  data-memory write enable
- `RegWriteM`  out  1  memory-stage register write (forwarding qualifier)
- `RegWriteW`  out  1  register-file write enable
- `ResultSrcW`  out  2  00 ALU result, 01 memory read data, 10 PC+4

## Operation
Decode is combinational from D inputs.

Opcode table:
- 0000011 load: RegWrite=1, ImmSrc=00, ALUSrc=1, MemWrite=0, ResultSrc=01, ALUOp=00
- 0100011 store: RegWrite=0, ImmSrc=01, ALUSrc=1, MemWrite=1, ALUOp=00
- 0110011 R-type: RegWrite=1, ALUSrc=0, ResultSrc=00, ALUOp=10
- 0010011 I-type ALU: RegWrite=1, ImmSrc=00, ALUSrc=1, ResultSrc=00, ALUOp=10
- 1100011 branch: Branch=1, ImmSrc=10, ALUSrc=0, ALUOp=01
- 1101111 jal: RegWrite=1, ImmSrc=11, Jump=1, ResultSrc=10
- Any other opcode: all control bits 0 (bubble); ImmSrcD=00.

ALU decoder:
- ALUOp 00 → add; ALUOp 01 → sub.
- ALUOp 10 selects by func3:
  - 000: sub if `opcode[5] & func7[5]`, else add
  - 010: slt
  - 110: or
  - 111: and
  - other func3: add

Pipeline registers:
- D→E: RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc, plus BranchNe when `CTRL_BNE_EN` is defined.
- E→M: RegWrite, ResultSrc, MemWrite.
- M→W: RegWrite, ResultSrc.
- No stall input: the E, M and W registers advance every cycle.
- `FlushE`=1: the D→E register loads all zeros. E→M still captures the current E contents.
- `PCSrcE = (BranchE & taken) | JumpE`, combinational from E registers and `zeroE`, where taken = `zeroE` (beq).
- `PCSrcE` does not flush by itself; the hazard unit asserts FlushD/FlushE in response.

## Timing
- Reset values: every pipeline register is 0. Therefore `PCSrcE`, `ALUSrcE`, `ALUControlE`, `ResultSrcE0`, `MemWriteM`, `RegWriteM`, `RegWriteW`, `ResultSrcW` are all 0 in the cycle after reset.
- `ImmSrcD` is combinational and follows `opcode` even during reset.
- Latency, for an instruction in D at cycle n:
  - E outputs valid in n+1 (`PCSrcE` also depends on `zeroE` in n+1)
  - M outputs valid in n+2
  - W outputs valid in n+3
- Reset mid-operation: all in-flight control is discarded at that edge. No register write or memory write issues afterwards until new instructions reach M/W.
- Reset and `FlushE` together: reset wins; the result is identical (all zero).
- A flushed slot propagates as a bubble: RegWrite=0 and MemWrite=0 in M at n+2 and W at n+3.

## Configuration
- `CTRL_BNE_EN` defined:
  - Branch with func3=001 decodes as bne: Branch=1, BranchNe=1 registered into E.
  - taken = `zeroE ^ BranchNeE`.
  - func3 values other than 000/001 on the branch opcode decode as bubble.
- Not defined:
  - BranchNe register is absent; taken = `zeroE`.
  - Branch opcode with func3≠000 decodes as bubble (never taken, no writes).

## Test plan
- lw (0000011, func3 010) decoded at cycle 1:
  - ImmSrcD=00 in cycle 1
  - cycle 2: ALUSrcE=1, ALUControlE=000, ResultSrcE0=1
  - cycle 3: MemWriteM=0, RegWriteM=1
  - cycle 4: RegWriteW=1, ResultSrcW=01
- R-type sub (func3 000, func7 0100000) → ALUControlE=001, ALUSrcE=0. addi with func7[5]=1 → ALUControlE=000.
- beq with zeroE=1 in E → PCSrcE=1. Same with zeroE=0 → PCSrcE=0. jal → PCSrcE=1 regardless of zeroE, and ResultSrcW=10 three cycles later.
- sw decoded with FlushE=1 on the next edge → ALUSrcE=0, then MemWriteM=0 and RegWriteW=0 in the following cycles.
- reset asserted while lw is in M and sw is in E → next cycle MemWriteM=0, RegWriteW=0, ResultSrcW=00, PCSrcE=0.
- With `CTRL_BNE_EN`: func3=001 branch with zeroE=0 → PCSrcE=1. Without it: same stimulus → PCSrcE=0, with all writes 0.
